// File: rtl/convolver_stream.sv
// Streaming 2-D "valid" convolution of a row-major n x n feature map with a static k x k kernel.
// Q-format products are summed at full precision, shifted right by Q and saturated to N bits.
module convolver_stream #(
  parameter int n = 4,
  parameter int k = 3,
  parameter int N = 16,
  parameter int Q = 12
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic signed [N-1:0] activation_i,
  input  logic signed [N-1:0] weights_i [k][k],
  output logic signed [N-1:0] conv_o,
  output logic                val_conv_o,
  output logic                done_conv_o
);

  localparam int CntW    = (n > 1) ? $clog2(n) : 1;
  localparam int HistLen = (k - 1) * n + k - 1;
  localparam int RegLen  = (HistLen > 0) ? HistLen : 1;
  localparam int PW      = 2 * N;
  localparam int SumW    = 2 * N + $clog2(k * k);
  localparam logic [CntW-1:0] LastIdx  = CntW'(n - 1);
  localparam logic [CntW-1:0] FirstOut = CntW'(k - 1);

  logic [CntW-1:0]     r_row;
  logic [CntW-1:0]     r_col;
  // Previous pixels, newest first; (k-1) full rows plus the k-1 pixels left of the current one.
  logic signed [N-1:0] r_hist [RegLen];

  logic signed [N-1:0]    w_tap [HistLen+1];
  logic signed [PW-1:0]   w_prod;
  logic signed [SumW-1:0] w_sum;
  logic signed [SumW-1:0] w_shift;
  logic [SumW-N:0]        w_hi;
  logic                   w_fits;
  logic signed [N-1:0]    w_res;
  logic                   w_win_ok;
  logic                   w_last;

  // Tap m is the pixel accepted m pixels ago; tap 0 is the one arriving this cycle.
  always_comb begin
    w_tap[0] = activation_i;
    for (int m = 1; m <= HistLen; m++) begin
      w_tap[m] = r_hist[m-1];
    end
  end

  always_comb begin
    w_prod = '0;
    w_sum  = '0;
    for (int i = 0; i < k; i++) begin
      for (int j = 0; j < k; j++) begin
        w_prod = PW'(w_tap[(k-1-i)*n + (k-1-j)]) * PW'(weights_i[i][j]);
        w_sum  = w_sum + SumW'(w_prod);
      end
    end
  end

  always_comb begin
    w_shift = w_sum >>> Q;
    w_hi    = w_shift[SumW-1:N-1];
    w_fits  = (&w_hi) | ~(|w_hi);
    if (w_fits) begin
      w_res = w_shift[N-1:0];
    end else if (w_shift[SumW-1]) begin
      w_res = {1'b1, {(N-1){1'b0}}};
    end else begin
      w_res = {1'b0, {(N-1){1'b1}}};
    end
  end

  assign w_win_ok = (r_row >= FirstOut) && (r_col >= FirstOut);
  assign w_last   = (r_row == LastIdx) && (r_col == LastIdx);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_row       <= '0;
      r_col       <= '0;
      conv_o      <= '0;
      val_conv_o  <= 1'b0;
      done_conv_o <= 1'b0;
      for (int m = 0; m < RegLen; m++) begin
        r_hist[m] <= '0;
      end
    end else begin
      val_conv_o  <= en_i && w_win_ok;
      done_conv_o <= en_i && w_last;
      if (en_i) begin
        r_hist[0] <= activation_i;
        for (int m = 1; m < RegLen; m++) begin
          r_hist[m] <= r_hist[m-1];
        end
        if (w_win_ok) begin
          conv_o <= w_res;
        end
        if (r_col == LastIdx) begin
          r_col <= '0;
          r_row <= (r_row == LastIdx) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_convolver_stream.sv
// Bench for convolver_stream: directed image scenarios plus randomized streaming, checked every
// cycle against an image-array reference model for both Q=0 and Q=12 instances.
module tb_convolver_stream;

  localparam int n = 4;
  localparam int k = 3;
  localparam int N = 16;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic                en_i;
  logic [N-1:0]        act;
  logic signed [N-1:0] wts [k][k];
  logic [N-1:0]        conv0, conv12;
  logic                val0, val12, done0, done12;

  convolver_stream #(.n(n), .k(k), .N(N), .Q(0)) u_dut_q0 (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .en_i         (en_i),
    .activation_i (act),
    .weights_i    (wts),
    .conv_o       (conv0),
    .val_conv_o   (val0),
    .done_conv_o  (done0)
  );

  convolver_stream #(.n(n), .k(k), .N(N), .Q(12)) u_dut_q12 (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .en_i         (en_i),
    .activation_i (act),
    .weights_i    (wts),
    .conv_o       (conv12),
    .val_conv_o   (val12),
    .done_conv_o  (done12)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: the image as a 2-D array, windows summed directly from it.
  int           mrow = 0;
  int           mcol = 0;
  longint       img [n][n];
  logic         exp_val  = 1'b0;
  logic         exp_done = 1'b0;
  logic [N-1:0] exp_c [2];

  logic [N-1:0] got0 [$];
  logic [N-1:0] got12 [$];
  int           gotcyc [$];
  int           donecyc [$];

  int t1_vals [4] = '{258, 294, 402, 438};
  int t1_cyc [4]  = '{11, 12, 15, 16};

  function automatic logic [N-1:0] sat_shift(input longint s, input int q);
    longint t, hi, lo;
    t  = s >>> q;
    hi = (longint'(1) <<< (N - 1)) - 1;
    lo = -(longint'(1) <<< (N - 1));
    if (t > hi) t = hi;
    else if (t < lo) t = lo;
    return t[N-1:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_edge();
    longint s;
    if (!rst_i) begin
      mrow = 0;
      mcol = 0;
      exp_val  = 1'b0;
      exp_done = 1'b0;
      exp_c[0] = '0;
      exp_c[1] = '0;
    end else if (en_i) begin
      img[mrow][mcol] = longint'($signed(act));
      exp_val  = (mrow >= k - 1) && (mcol >= k - 1);
      exp_done = (mrow == n - 1) && (mcol == n - 1);
      if (exp_val) begin
        s = 0;
        for (int i = 0; i < k; i++)
          for (int j = 0; j < k; j++)
            s += img[mrow-k+1+i][mcol-k+1+j] * longint'(wts[i][j]);
        exp_c[0] = sat_shift(s, 0);
        exp_c[1] = sat_shift(s, 12);
      end
      mcol++;
      if (mcol == n) begin
        mcol = 0;
        mrow = (mrow + 1) % n;
      end
    end else begin
      exp_val  = 1'b0;
      exp_done = 1'b0;
    end
  endtask

  task automatic step(input logic rst, input logic en, input logic [N-1:0] a);
    rst_i = rst;
    en_i  = en;
    act   = a;
    @(posedge clk_i);
    model_edge();
    #1;
    cyc++;
    chk("val_q0", 32'(val0), 32'(exp_val));
    chk("val_q12", 32'(val12), 32'(exp_val));
    chk("done_q0", 32'(done0), 32'(exp_done));
    chk("done_q12", 32'(done12), 32'(exp_done));
    chk("conv_q0", 32'(conv0), 32'(exp_c[0]));
    chk("conv_q12", 32'(conv12), 32'(exp_c[1]));
    if (val0 === 1'b1) begin
      got0.push_back(conv0);
      gotcyc.push_back(cyc);
    end
    if (val12 === 1'b1) got12.push_back(conv12);
    if (done0 === 1'b1) donecyc.push_back(cyc);
  endtask

  task automatic set_w_ramp();
    for (int i = 0; i < k; i++)
      for (int j = 0; j < k; j++)
        wts[i][j] = N'(3 * i + j);
  endtask

  task automatic set_w_const(input logic [N-1:0] v);
    for (int i = 0; i < k; i++)
      for (int j = 0; j < k; j++)
        wts[i][j] = v;
  endtask

  task automatic clear_log();
    got0.delete();
    got12.delete();
    gotcyc.delete();
    donecyc.delete();
    cyc = 0;
  endtask

  task automatic chk_q0_vals(input string tag);
    chk({tag, "_count"}, 32'(got0.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk({tag, "_val"}, (i < got0.size()) ? 32'(got0[i]) : 32'hffff_ffff, 32'(t1_vals[i]));
  endtask

  task automatic chk_q12_all(input string tag, input logic [N-1:0] v);
    chk({tag, "_count"}, 32'(got12.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk({tag, "_val"}, (i < got12.size()) ? 32'(got12[i]) : 32'hffff_ffff, 32'(v));
  endtask

  initial begin
    logic [N-1:0] a;
    exp_c[0] = '0;
    exp_c[1] = '0;
    rst_i = 1'b0;
    en_i  = 1'b0;
    act   = '0;
    set_w_ramp();

    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 16'h1234);
    chk("reset_conv", 32'(conv0), 32'd0);
    chk("reset_val", 32'(val0), 32'd0);
    chk("reset_done", 32'(done0), 32'd0);

    // Ramp kernel, pixels 0..15 back to back from cycle 0.
    clear_log();
    for (int p = 0; p < 16; p++) step(1'b1, 1'b1, N'(p));
    chk_q0_vals("ramp");
    for (int i = 0; i < 4; i++)
      chk("ramp_cycle", (i < gotcyc.size()) ? 32'(gotcyc[i]) : 32'hffff_ffff, 32'(t1_cyc[i]));
    chk("ramp_done_n", 32'(donecyc.size()), 32'd1);
    chk("ramp_done_cyc", (donecyc.size() > 0) ? 32'(donecyc[0]) : 32'hffff_ffff, 32'd16);

    set_w_const(16'h0800);
    clear_log();
    for (int p = 0; p < 16; p++) step(1'b1, 1'b1, 16'h1000);
    chk_q12_all("half", 16'h4800);

    set_w_const(16'h1000);
    clear_log();
    for (int p = 0; p < 16; p++) step(1'b1, 1'b1, 16'h1000);
    chk_q12_all("sat_pos", 16'h7fff);

    clear_log();
    for (int p = 0; p < 16; p++) step(1'b1, 1'b1, 16'hf000);
    chk_q12_all("sat_neg", 16'h8000);

    // Three-cycle stall after every second pixel.
    set_w_ramp();
    clear_log();
    for (int p = 0; p < 16; p++) begin
      step(1'b1, 1'b1, N'(p));
      if (p % 2 == 1) begin
        for (int s = 0; s < 3; s++) begin
          step(1'b1, 1'b0, N'($urandom));
          chk("stall_val", 32'(val0), 32'd0);
        end
      end
    end
    chk_q0_vals("stall");
    chk("stall_done_n", 32'(donecyc.size()), 32'd1);

    // Reset after pixel 7, then a full image.
    for (int p = 0; p < 8; p++) step(1'b1, 1'b1, N'(p));
    step(1'b0, 1'b1, 16'd99);
    chk("midrst_conv0", 32'(conv0), 32'd0);
    chk("midrst_conv12", 32'(conv12), 32'd0);
    chk("midrst_val", 32'(val0), 32'd0);
    chk("midrst_done", 32'(done0), 32'd0);
    clear_log();
    for (int p = 0; p < 16; p++) step(1'b1, 1'b1, N'(p));
    chk_q0_vals("midrst");

    // Two images with no gap.
    clear_log();
    for (int p = 0; p < 32; p++) step(1'b1, 1'b1, N'(p % 16));
    chk("b2b_count", 32'(got0.size()), 32'd8);
    chk("b2b_done_n", 32'(donecyc.size()), 32'd2);
    chk("b2b_done0", (donecyc.size() > 0) ? 32'(donecyc[0]) : 32'hffff_ffff, 32'd16);
    chk("b2b_done1", (donecyc.size() > 1) ? 32'(donecyc[1]) : 32'hffff_ffff, 32'd32);

    // Randomized streaming with stalls, resets and weight changes between edges.
    for (int t = 0; t < 800; t++) begin
      if ($urandom_range(0, 39) == 0) begin
        for (int i = 0; i < k; i++)
          for (int j = 0; j < k; j++)
            wts[i][j] = ($urandom_range(0, 1) == 1) ? N'($urandom)
                                                     : N'(int'($urandom_range(0, 8191)) - 4096);
      end
      a = ($urandom_range(0, 1) == 1) ? N'($urandom) : N'(int'($urandom_range(0, 8191)) - 4096);
      step(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) != 0), a);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
